// File: rtl/i2s_playback_apb_mc.sv
// i2s_playback_apb_mc: APB playback front-end for the I2S output path.
// Accepts signed PCM samples via APB register writes (CPU or DMA), applies
// per-channel volume/mute, assembles CHANNELS-wide frames and buffers them in
// a show-ahead frame FIFO. Frames leave on a valid/ready stream in clk domain.
// Optional build macro: I2S_PLAYBACK_STATS_EN adds saturating underrun and
// overflow event counters at 0x10 / 0x14.
module i2s_playback_apb_mc #(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [5:0]                   paddr,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [31:0]                  pwdata,
    output logic [31:0]                  prdata,
    output logic                         pready,
    output logic [CHANNELS*SAMPLE_W-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         dma_req,
    input  logic                         dma_ack,
    output logic                         dma_enable
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = CHANNELS * SAMPLE_W;
    localparam int AW = $clog2(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic setup_rd, wr_commit;
    logic data_wr, ctrl_wr, wm_wr;
    logic fifo_clear, sticky_clear;
    logic unused_pwdata;

    assign pready       = 1'b1;
    assign setup_rd     = psel & ~penable & ~pwrite;
    assign wr_commit    = psel & penable & pwrite;
    assign data_wr      = wr_commit & (paddr == 6'h00);
    assign ctrl_wr      = wr_commit & (paddr == 6'h08);
    assign wm_wr        = wr_commit & (paddr == 6'h0C);
    assign fifo_clear   = ctrl_wr & pwdata[0];
    assign sticky_clear = ctrl_wr & pwdata[2];
    assign unused_pwdata = ^pwdata;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0]       chan_ptr_reg;
    logic [LW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]       wm_reg;
    logic                dma_en_reg;
    logic                dma_req_reg;
    logic                underrun_reg, overflow_reg;
    logic [3:0]          vol_att_reg  [CHANNELS];
    logic                vol_mute_reg [CHANNELS];
    logic [SAMPLE_W-1:0] slot_reg     [CHANNELS];
    logic [FW-1:0]       fifo_mem     [FIFO_DEPTH];

    assign dma_enable = dma_en_reg;
    assign dma_req    = dma_req_reg;

    // ------------------------------------------------------------------
    // Volume scaling of the incoming sample for the current channel
    // ------------------------------------------------------------------
    logic [3:0]                cur_att;
    logic                      cur_mute;
    logic [2:0]                shift;
    logic [3:0]                shift2;
    logic signed [SAMPLE_W:0]  s_ext, term_a, term_b, y_full;
    logic [SAMPLE_W-1:0]       y;

    assign cur_att  = vol_att_reg[chan_ptr_reg];
    assign cur_mute = vol_mute_reg[chan_ptr_reg];
    assign shift    = cur_att[3:1];
    assign shift2   = {1'b0, shift} + 4'd2;
    assign s_ext    = {pwdata[SAMPLE_W-1], pwdata[SAMPLE_W-1:0]};

    // Attenuation: s/2^k minus an optional extra quarter step, one guard bit
    always_comb begin
        term_a = s_ext >>> shift;
        term_b = '0;
        if (cur_att[0]) begin
            term_b = s_ext >>> shift2;
        end
        y_full = term_a - term_b;
        y      = cur_mute ? '0 : y_full[SAMPLE_W-1:0];
    end

    // ------------------------------------------------------------------
    // Frame assembly: the last channel's sample bypasses its slot register
    // so the frame is pushed on the same write.
    // ------------------------------------------------------------------
    logic [FW-1:0] frame_word;
    logic          last_slot;

    assign last_slot = (chan_ptr_reg == CW'(CHANNELS - 1));

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            if (gi == CHANNELS - 1) begin : g_last
                assign frame_word[gi*SAMPLE_W +: SAMPLE_W] = y;
            end else begin : g_slot
                assign frame_word[gi*SAMPLE_W +: SAMPLE_W] = slot_reg[gi];
            end

            // Per-channel volume register and sample slot
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vol_att_reg[gi]  <= '0;
                    vol_mute_reg[gi] <= 1'b0;
                    slot_reg[gi]     <= '0;
                end else begin
                    if (wr_commit && paddr == 6'(32 + 4 * gi)) begin
                        vol_att_reg[gi]  <= pwdata[3:0];
                        vol_mute_reg[gi] <= pwdata[8];
                    end
                    if (data_wr && chan_ptr_reg == CW'(gi)) begin
                        slot_reg[gi] <= y;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [LW-1:0] level;
    logic          empty, full;
    logic          frame_push, pop, push_ok, drop, underrun_evt;

    assign level        = wr_ptr_reg - rd_ptr_reg;
    assign empty        = (level == '0);
    assign full         = (level == LW'(FIFO_DEPTH));
    assign frame_push   = data_wr & last_slot;
    assign pop          = ~empty & out_ready;
    // A pop in the same cycle frees the slot, so a push at full still lands
    assign push_ok      = frame_push & (~full | pop);
    assign drop         = frame_push & full & ~pop;
    assign underrun_evt = out_ready & empty;

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : fifo_mem[rd_ptr_reg[AW-1:0]];

    // Frame storage write port (no reset on the array)
    always_ff @(posedge clk) begin
        if (push_ok && !fifo_clear) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= frame_word;
        end
    end

    // Pointers and channel pointer; clear overrides push/pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            chan_ptr_reg <= '0;
        end else if (fifo_clear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            chan_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + LW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + LW'(1);
            end
            if (data_wr) begin
                chan_ptr_reg <= last_slot ? '0 : chan_ptr_reg + CW'(1);
            end
        end
    end

    // Control, watermark, sticky status and DMA request registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_en_reg   <= 1'b0;
            wm_reg       <= '0;
            underrun_reg <= 1'b0;
            overflow_reg <= 1'b0;
            dma_req_reg  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                dma_en_reg <= pwdata[1];
            end
            if (wm_wr) begin
                wm_reg <= pwdata[LW-1:0];
            end
            // A new event in the clear cycle keeps the sticky bit set
            underrun_reg <= underrun_evt | (underrun_reg & ~sticky_clear);
            overflow_reg <= drop | (overflow_reg & ~sticky_clear);
            dma_req_reg  <= dma_ack ? 1'b0 : (dma_en_reg & (level < wm_reg) & ~full);
        end
    end

`ifdef I2S_PLAYBACK_STATS_EN
    logic [15:0] underrun_cnt_reg, overflow_cnt_reg;
    logic        cnt_clear;

    assign cnt_clear = sticky_clear | fifo_clear;

    // Saturating event counters; an event in the clear cycle counts as one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt_reg <= '0;
            overflow_cnt_reg <= '0;
        end else begin
            if (cnt_clear) begin
                underrun_cnt_reg <= {15'd0, underrun_evt};
                overflow_cnt_reg <= {15'd0, drop};
            end else begin
                if (underrun_evt && underrun_cnt_reg != 16'hFFFF) begin
                    underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
                end
                if (drop && overflow_cnt_reg != 16'hFFFF) begin
                    overflow_cnt_reg <= overflow_cnt_reg + 16'd1;
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [7:0]  level_byte;
    logic [2:0]  chan_bits;
    logic [31:0] rd_mux;

    // Zero-extend / fit level and channel pointer into their status fields
    always_comb begin
        level_byte = '0;
        chan_bits  = '0;
        for (int i = 0; i < LW && i < 8; i++) begin
            level_byte[i] = level[i];
        end
        for (int i = 0; i < CW && i < 3; i++) begin
            chan_bits[i] = chan_ptr_reg[i];
        end
    end

    // Register read data selection
    always_comb begin
        rd_mux = '0;
        case (paddr)
            6'h04: rd_mux = {13'd0, chan_bits, level_byte, 2'b00, overflow_reg,
                             underrun_reg, dma_req_reg, dma_en_reg, full, empty};
            6'h08: rd_mux = {30'd0, dma_en_reg, 1'b0};
            6'h0C: rd_mux = 32'(wm_reg);
`ifdef I2S_PLAYBACK_STATS_EN
            6'h10: rd_mux = {16'd0, underrun_cnt_reg};
            6'h14: rd_mux = {16'd0, overflow_cnt_reg};
`endif
            default: rd_mux = '0;
        endcase
        for (int c = 0; c < CHANNELS; c++) begin
            if (paddr == 6'(32 + 4 * c)) begin
                rd_mux = {23'd0, vol_mute_reg[c], 4'd0, vol_att_reg[c]};
            end
        end
    end

    // Read data is captured in the setup phase and held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prdata <= '0;
        end else if (setup_rd) begin
            prdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_i2s_playback_apb_mc.sv
// Self-checking bench for i2s_playback_apb_mc (default parameters).
// A queue-based model predicts stream, DMA and read-data outputs every cycle;
// directed steps add hand-computed literal expectations.
module tb_i2s_playback_apb_mc;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        dma_req;
    logic        dma_ack = 1'b0;
    logic        dma_enable;

    int n_checks = 0;
    int n_err    = 0;

    i2s_playback_apb_mc dut (
        .clk(clk), .reset_n(reset_n),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .dma_req(dma_req), .dma_ack(dma_ack), .dma_enable(dma_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] mq[$];
    logic [15:0] m_slot[2];
    int          m_cp = 0;
    logic [3:0]  m_att[2];
    logic        m_mute[2];
    bit          m_dma_en = 0, m_dma_req = 0, m_under = 0, m_over = 0;
    int          m_wm = 0;
    logic [31:0] m_prdata = '0;
    int          m_ucnt = 0, m_ocnt = 0;

    function automatic logic [15:0] m_scale(input logic [15:0] s, input logic [3:0] a, input logic m);
        int sv, k, yv;
        sv = int'($signed(s));
        k  = int'(a[3:1]);
        yv = (sv >>> k) - (a[0] ? (sv >>> (k + 2)) : 0);
        return m ? 16'h0 : yv[15:0];
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        logic [31:0] r;
        int lvl;
        lvl = mq.size();
        r = '0;
        case (a)
            6'h04: begin
                r[0] = (lvl == 0);
                r[1] = (lvl == 16);
                r[2] = m_dma_en;
                r[3] = m_dma_req;
                r[4] = m_under;
                r[5] = m_over;
                r[15:8] = 8'(lvl);
                r[18:16] = 3'(m_cp);
            end
            6'h08: r[1] = m_dma_en;
            6'h0C: r = 32'(m_wm);
`ifdef I2S_PLAYBACK_STATS_EN
            6'h10: r = 32'(m_ucnt);
            6'h14: r = 32'(m_ocnt);
`endif
            6'h20: r = {23'd0, m_mute[0], 4'd0, m_att[0]};
            6'h24: r = {23'd0, m_mute[1], 4'd0, m_att[1]};
            default: r = '0;
        endcase
        return r;
    endfunction

    bit          e_wr, e_pop, e_under, e_nreq, e_clr, e_sclr, e_push, e_drop;
    int          e_lvl;
    logic [15:0] e_y;

    initial begin
        m_slot[0] = '0; m_slot[1] = '0;
        m_att[0] = '0; m_att[1] = '0;
        m_mute[0] = 0; m_mute[1] = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                m_cp = 0; m_dma_en = 0; m_dma_req = 0; m_under = 0; m_over = 0;
                m_wm = 0; m_prdata = '0; m_ucnt = 0; m_ocnt = 0;
                m_slot[0] = '0; m_slot[1] = '0;
                m_att[0] = '0; m_att[1] = '0; m_mute[0] = 0; m_mute[1] = 0;
            end else begin
                e_wr    = psel && penable && pwrite;
                e_lvl   = mq.size();
                e_pop   = (e_lvl > 0) && out_ready;
                e_under = out_ready && (e_lvl == 0);
                e_nreq  = dma_ack ? 0 : (m_dma_en && e_lvl < m_wm && e_lvl < 16);
                e_clr   = e_wr && paddr == 6'h08 && pwdata[0];
                e_sclr  = e_wr && paddr == 6'h08 && pwdata[2];
                e_push  = 0;
                e_drop  = 0;
                if (psel && !penable && !pwrite) m_prdata = m_read(paddr);
                if (e_wr) begin
                    case (paddr)
                        6'h00: begin
                            e_y = m_scale(pwdata[15:0], m_att[m_cp], m_mute[m_cp]);
                            m_slot[m_cp] = e_y;
                            if (m_cp == 1) begin
                                if (e_lvl < 16 || e_pop) e_push = 1;
                                else e_drop = 1;
                                m_cp = 0;
                            end else begin
                                m_cp = 1;
                            end
                        end
                        6'h08: m_dma_en = pwdata[1];
                        6'h0C: m_wm = int'(pwdata[4:0]);
                        6'h20: begin m_att[0] = pwdata[3:0]; m_mute[0] = pwdata[8]; end
                        6'h24: begin m_att[1] = pwdata[3:0]; m_mute[1] = pwdata[8]; end
                        default: ;
                    endcase
                end
                if (e_sclr || e_clr) begin
                    m_ucnt = 0;
                    m_ocnt = 0;
                end
                if (e_under && m_ucnt < 65535) m_ucnt++;
                if (e_drop && m_ocnt < 65535) m_ocnt++;
                if (e_sclr) begin m_under = 0; m_over = 0; end
                if (e_under) m_under = 1;
                if (e_drop)  m_over = 1;
                if (e_clr) begin
                    mq.delete();
                    m_cp = 0;
                end else begin
                    if (e_pop) void'(mq.pop_front());
                    if (e_push) mq.push_back({m_slot[1], m_slot[0]});
                end
                m_dma_req = e_nreq;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            check("out_data", out_data, (mq.size() > 0) ? mq[0] : 32'h0);
            check("dma_req", 32'(dma_req), 32'(m_dma_req));
            check("dma_enable", 32'(dma_enable), 32'(m_dma_en));
            check("prdata", prdata, m_prdata);
            check("pready", 32'(pready), 32'h1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
        $display("APB write addr=%h data=%h", a, d);
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge clk); #1;
        penable = 1;
        d = prdata;
        @(posedge clk); #1;
        psel = 0; penable = 0;
        $display("APB read  addr=%h data=%h", a, d);
    endtask

    task automatic read_check(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(name, d, exp);
    endtask

    task automatic pop_one();
        @(posedge clk); #1;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        $display("stream pop");
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        // Reset state
        read_check("reset_status", 6'h04, 32'h0000_0001);
        read_check("reset_ctrl", 6'h08, 32'h0);
        read_check("reset_vol0", 6'h20, 32'h0);

        // Basic frame at full scale
        apb_write(6'h00, 32'h0000_1234);
        read_check("status_half_frame", 6'h04, 32'h0001_0001);
        apb_write(6'h00, 32'h0000_8000);
        check("frame0_data", out_data, 32'h8000_1234);
        read_check("status_one_frame", 6'h04, 32'h0000_0100);
        read_check("data_reads_zero", 6'h00, 32'h0);
        read_check("unmapped_zero", 6'h18, 32'h0);
        read_check("cnt_reads", 6'h10, 32'h0);
        pop_one();

        // Volume and mute
        apb_write(6'h20, 32'h3);
        apb_write(6'h00, 32'h0000_4000);
        apb_write(6'h00, 32'h0000_0000);
        check("vol3_frame", out_data, 32'h0000_1800);
        pop_one();
        apb_write(6'h24, 32'h100);
        read_check("vol1_readback", 6'h24, 32'h0000_0100);
        apb_write(6'h00, 32'h0000_4000);
        apb_write(6'h00, 32'h0000_7FFF);
        check("mute_frame", out_data, 32'h0000_1800);
        pop_one();
        apb_write(6'h20, 32'h5);
        apb_write(6'h24, 32'h0);
        apb_write(6'h00, 32'h0000_8000);
        apb_write(6'h00, 32'h0000_8000);
        check("neg_scale_frame", out_data, 32'h8000_E800);
        pop_one();
        apb_write(6'h20, 32'h0);

        // Overflow: 17 frames into a 16-deep FIFO
        for (int i = 1; i <= 17; i++) begin
            apb_write(6'h00, 32'(i));
            apb_write(6'h00, 32'(i + 16'h100));
        end
        check("ovf_head", out_data, 32'h0101_0001);
        read_check("status_full", 6'h04, 32'h0000_1022);
        @(posedge clk); #1;
        out_ready = 1;
        repeat (16) @(posedge clk);
        #1 out_ready = 0;
        check("drained_valid", 32'(out_valid), 32'h0);
        read_check("status_drained", 6'h04, 32'h0000_0021);
        apb_write(6'h08, 32'h4);
        read_check("status_sticky_clr", 6'h04, 32'h0000_0001);

        // Underrun
        @(posedge clk); #1;
        out_ready = 1;
        @(posedge clk); #1;
        check("underrun_data", out_data, 32'h0);
        out_ready = 0;
        read_check("status_underrun", 6'h04, 32'h0000_0011);
        apb_write(6'h08, 32'h4);
        read_check("status_underrun_clr", 6'h04, 32'h0000_0001);

        // DMA request with watermark 4
        apb_write(6'h0C, 32'h4);
        apb_write(6'h08, 32'h2);
        @(posedge clk); #1;
        check("dma_req_on", 32'(dma_req), 32'h1);
        dma_ack = 1;
        @(posedge clk); #1;
        check("dma_req_ack", 32'(dma_req), 32'h0);
        dma_ack = 0;
        @(posedge clk); #1;
        check("dma_req_back", 32'(dma_req), 32'h1);
        read_check("status_dma", 6'h04, 32'h0000_000D);
        read_check("wm_readback", 6'h0C, 32'h4);
        for (int i = 0; i < 4; i++) begin
            apb_write(6'h00, 32'h10 + 32'(i));
            apb_write(6'h00, 32'h20 + 32'(i));
        end
        @(posedge clk); #1;
        check("dma_req_at_wm", 32'(dma_req), 32'h0);
        read_check("status_level4", 6'h04, 32'h0000_0404);

        // FIFO clear discards partial frame and contents
        apb_write(6'h00, 32'h0000_7777);
        read_check("status_partial", 6'h04, 32'h0001_0404);
        apb_write(6'h08, 32'h1);
        read_check("status_cleared", 6'h04, 32'h0000_0001);
        apb_write(6'h00, 32'h0000_AAAA);
        apb_write(6'h00, 32'h0000_5555);
        check("clean_frame", out_data, 32'h5555_AAAA);
        read_check("status_clean", 6'h04, 32'h0000_0100);

        // Asynchronous reset mid-operation
        apb_write(6'h20, 32'h7);
        apb_write(6'h00, 32'h0000_1111);
        @(posedge clk); #3;
        reset_n = 0;
        #4 reset_n = 1;
        check("reset_valid", 32'(out_valid), 32'h0);
        read_check("status_after_reset", 6'h04, 32'h0000_0001);
        read_check("vol0_after_reset", 6'h20, 32'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
